// File: rtl/rom_fetch_arbiter_if.sv
// Bundles the two requester ports and the ROM bus of rom_fetch_arbiter.
// master: the requesters and the ROM; slave: the arbiter.
interface rom_fetch_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 14
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;

    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          oor_err;

    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, rom_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, rom_addr, oor_err
    );

    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, rom_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, rom_addr, oor_err
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the combinational program ROM between the core
// fetch port and the debug readback port. One read every two cycles, fetch
// has priority over debug.
// Optional build macro ROM_ARB_STARVE_EN: debug is forced to win once it has
// lost STARVE_MAX arbitrations in a row.
//
// state | meaning
// IDLE  | may grant one requester (combinational grant)
// BUSY  | ROM addressed with addr_q; word captured at the end of this cycle
module rom_fetch_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 14,
    parameter int ROM_DEPTH  = 2048,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst_n,
    rom_fetch_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(ROM_DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          own_dbg_q;
    logic          oor_q;
    logic          force_dbg;
    logic          any_gnt;
    logic [AW-1:0] gnt_addr;
    logic          gnt_oor;

    assign any_gnt      = bus.fetch_gnt | bus.dbg_gnt;
    assign gnt_addr     = bus.dbg_gnt ? bus.dbg_addr : bus.fetch_addr;
    assign gnt_oor      = ({1'b0, gnt_addr} >= DEPTH_LIM);
    assign bus.rom_addr = addr_q;

`ifdef ROM_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    assign force_dbg = (starve_cnt == SW'(STARVE_MAX));

    // count debug losses to fetch; any debug grant restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (bus.dbg_gnt) begin
            starve_cnt <= '0;
        end else if (bus.fetch_gnt && bus.dbg_req && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    // strict priority: debug is never forced ahead of fetch, STARVE_MAX unused
    assign force_dbg = (STARVE_MAX < 0);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: a grant starts a two-cycle read
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_gnt) state_d = BUSY;
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // grant decode: at most one grant, only in IDLE
    always_comb begin
        bus.fetch_gnt = 1'b0;
        bus.dbg_gnt   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.dbg_req && (force_dbg || !bus.fetch_req)) bus.dbg_gnt = 1'b1;
            else if (bus.fetch_req)                            bus.fetch_gnt = 1'b1;
        end
    end

    // latch the granted read, then return the ROM word to its owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q           <= '0;
            own_dbg_q        <= 1'b0;
            oor_q            <= 1'b0;
            bus.oor_err      <= 1'b0;
            bus.fetch_rvalid <= 1'b0;
            bus.dbg_rvalid   <= 1'b0;
            bus.fetch_rdata  <= '0;
            bus.dbg_rdata    <= '0;
        end else begin
            bus.fetch_rvalid <= 1'b0;
            bus.dbg_rvalid   <= 1'b0;
            if (any_gnt) begin
                addr_q    <= gnt_addr;
                own_dbg_q <= bus.dbg_gnt;
                oor_q     <= gnt_oor;
                if (gnt_oor) bus.oor_err <= 1'b1;
            end
            if (state_q == BUSY) begin
                // out-of-range words read as zero whatever the ROM drives
                if (own_dbg_q) begin
                    bus.dbg_rvalid <= 1'b1;
                    bus.dbg_rdata  <= oor_q ? '0 : bus.rom_data;
                end else begin
                    bus.fetch_rvalid <= 1'b1;
                    bus.fetch_rdata  <= oor_q ? '0 : bus.rom_data;
                end
            end
        end
    end
endmodule

// File: doc/rom_fetch_arbiter.md
# rom_fetch_arbiter

Shares the single combinational program ROM (14-bit words, 11-bit word address) between two requesters: the core instruction-fetch port and the debug readback port used by the UART monitor. The block arbitrates, registers the winning address onto the ROM address bus, captures the returned word and routes it to the owning requester with a one-cycle valid pulse. It sits between the core/debug logic and `Program_Rom`, which is driven only through this block.

## Interface
- `AW`, 11, ROM word-address width
- `DW`, 14, ROM data width
- `ROM_DEPTH`, 2048, number of implemented words; addresses ≥ ROM_DEPTH are out of range
- `STARVE_MAX`, 4, lost arbitrations after which debug is forced to win (see Configuration)

- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `fetch_req` in 1 — core requests a read; held until `fetch_gnt`
- `fetch_addr` in AW — core address; stable while `fetch_req` is high
- `fetch_gnt` out 1 — request accepted this cycle
- `fetch_rvalid` out 1 — `fetch_rdata` valid; 1-cycle pulse
- `fetch_rdata` out DW — returned word
- `dbg_req`, `dbg_addr`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata` — same meanings and widths for the debug port
- `rom_addr` out AW — to ROM address input
- `rom_data` in DW — from ROM data output (combinational)
- `oor_err` out 1 — sticky: an out-of-range address was accepted; cleared only by reset

## Operation
- FSM: IDLE, BUSY.
- IDLE: grant is combinational. Only one grant per cycle. Default priority is fetch over debug.
  - Grant → latch address into `addr_q`, owner into `own_q`, go BUSY.
  - No request → stay IDLE; `rom_addr` holds the last `addr_q`.
- BUSY: `rom_addr = addr_q`. On the closing edge:
  - capture `rom_data` into the owner's rdata register;
  - pulse the owner's rvalid;
  - return to IDLE.
- No grants are issued in BUSY. A requester whose `req` is high in BUSY is not granted until the next IDLE cycle.
- Out-of-range address (`addr ≥ ROM_DEPTH`): the read is still granted, the rdata captured is 0, and `oor_err` sets on the grant edge.
- The non-owner's rdata register holds its previous value.
- Reset values: state IDLE; `addr_q` 0; `rom_addr` 0; both rdata 0; both rvalid 0; both gnt 0; `oor_err` 0; starvation counter 0.
- Reset asserted in BUSY aborts the read. No rvalid is produced, and the requester re-requests after reset.

## Timing
- Grant in cycle N, ROM addressed in N+1, rvalid/rdata in N+2. Latency from gnt is 2 cycles.
- A new grant is possible in N+2, the same cycle as rvalid. Peak throughput is 1 read per 2 cycles.
- `fetch_gnt` and `dbg_gnt` are never both high. Neither is high in BUSY.
- Simultaneous rvalid on both ports is impossible.
- `req` is sampled only in IDLE. Deasserting `req` before gnt withdraws the request with no side effect.

## Configuration
- `ROM_ARB_STARVE_EN` defined:
  - A saturating counter increments each IDLE cycle in which `dbg_req` loses to `fetch_req`.
  - When the count reaches `STARVE_MAX`, the next IDLE cycle with `dbg_req` high grants debug regardless of `fetch_req`, and the counter clears.
  - The counter also clears on any debug grant.
- Not defined: strict fixed priority. Debug can starve indefinitely, and no counter logic is synthesized.

## Test plan
- Reset, then fetch reads addr 0x000 → `fetch_gnt` in cycle N, `fetch_rvalid` in N+2 with `fetch_rdata` = 0x01A3, and `rom_addr` = 0x000 in N+1.
- Both ports request in the same IDLE cycle (fetch 0x024, dbg 0x013) → fetch granted first and returns 0x2800; dbg granted 2 cycles later and returns 0x1FA5; dbg rdata is unchanged until its own rvalid.
- Debug reads 0x030 (within range, unprogrammed) → `dbg_rdata` = 0x0000 and `oor_err` stays 0. With ROM_DEPTH=64, a debug read of 0x7FF → rdata 0x0000 and `oor_err` = 1, sticky until reset.
- With `ROM_ARB_STARVE_EN`, STARVE_MAX=4, fetch requesting continuously and dbg held high → exactly 4 fetch grants, then 1 dbg grant, then fetch resumes. Without the macro, dbg is never granted while fetch_req is held.
- `rst_n` pulsed low in the BUSY cycle of a fetch read → no `fetch_rvalid`, all outputs return to reset values immediately, and the next request completes normally.
- Back-to-back fetch reads of 0x005, 0x006, 0x007 → rvalid in cycles N+2, N+4, N+6 with data 0x0103, 0x1E91, 0x2806.
